// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding, channel indices and one-hot decode for the OLED SPI arbiter
package oled_pkg;
   localparam int NCH        = 3;
   localparam int CH_INIT    = 0;
   localparam int CH_REFRESH = 1;
   localparam int CH_USER    = 2;
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_HOLD  = 2'd3
   } arb_state_e;
   function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
      return oh[CH_USER] ? 2'(CH_USER) : oh[CH_REFRESH] ? 2'(CH_REFRESH) : 2'(CH_INIT);
   endfunction
endpackage

// File: rtl/oled_arb_pick.sv
// oled_arb_pick: combinational fixed-priority picker, lowest index wins, one-hot out
module oled_arb_pick
   import oled_pkg::*;
(
   input  logic [NCH-1:0] req_i,
   output logic [NCH-1:0] gnt_o
);
   assign gnt_o = req_i & (~req_i + NCH'(1));
endmodule

// File: rtl/oled_spi_arb.sv
// oled_spi_arb: shares one OLED SPI byte-writer between init, refresh and user channels.
// Define OLED_ARB_TIMEOUT_EN to add the WAIT watchdog and the timeout_err pulse.
module oled_spi_arb
   import oled_pkg::*;
`ifdef OLED_ARB_TIMEOUT_EN
   #(parameter int TIMEOUT_CYC = 4096)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req,
   input  logic [NCH-1:0]   lock,
   input  logic [NCH-1:0]   ch_dc,
   input  logic [8*NCH-1:0] ch_data,
   output logic [NCH-1:0]   gnt,
   output logic [NCH-1:0]   done,
   output logic             busy,
   output logic             spi_ena,
   output logic             spi_dc,
   output logic [7:0]       spi_data,
   input  logic             spi_done
`ifdef OLED_ARB_TIMEOUT_EN
   ,output logic            timeout_err
`endif
);
   arb_state_e     state_q, state_d;
   logic [NCH-1:0] gnt_q, gnt_d, done_q, done_d, pick, src;
   logic           busy_q, ena_q, dc_q, dc_d;
   logic [7:0]     data_q, data_d;
   logic [1:0]     idx;
   logic           own_req, own_lock, load, fin, tmo;

   oled_arb_pick u_pick (.req_i(req), .gnt_o(pick));

   assign own_req  = |(req & gnt_q);
   assign own_lock = |(lock & gnt_q);
   assign fin      = (state_q == ARB_WAIT) && spi_done;

`ifdef OLED_ARB_TIMEOUT_EN
   logic [12:0] cnt_q;
   logic        terr_q;
   assign tmo = (state_q == ARB_WAIT) && !spi_done && (cnt_q == 13'(TIMEOUT_CYC - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= state_q == ARB_ISSUE ? '0 : state_q == ARB_WAIT ? cnt_q + 13'd1 : cnt_q;
         terr_q <= tmo;
      end
   assign timeout_err = terr_q;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= ARB_IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE:  state_d = |req ? ARB_ISSUE : ARB_IDLE;
         ARB_ISSUE: state_d = ARB_WAIT;
         ARB_WAIT:  state_d = fin ? (own_lock ? ARB_HOLD : ARB_IDLE) : tmo ? ARB_IDLE : ARB_WAIT;
         ARB_HOLD:  state_d = own_req ? ARB_ISSUE : own_lock ? ARB_HOLD : ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   // HOLD re-issues for the owner only; IDLE captures from the fresh pick
   always_comb begin
      load   = (state_q == ARB_IDLE && |req) || (state_q == ARB_HOLD && own_req);
      src    = state_q == ARB_IDLE ? pick : gnt_q;
      idx    = oh2idx(src);
      gnt_d  = state_d == ARB_IDLE ? '0 : state_q == ARB_IDLE ? pick : gnt_q;
      done_d = (fin || tmo) ? gnt_q : '0;
      dc_d   = load ? ch_dc[idx] : dc_q;
      data_d = load ? ch_data[{idx, 3'b000} +: 8] : data_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt_q  <= '0;
         done_q <= '0;
         busy_q <= 1'b0;
         ena_q  <= 1'b0;
         dc_q   <= 1'b0;
         data_q <= '0;
      end else begin
         gnt_q  <= gnt_d;
         done_q <= done_d;
         busy_q <= state_d != ARB_IDLE;
         ena_q  <= state_d == ARB_ISSUE;
         dc_q   <= dc_d;
         data_q <= data_d;
      end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign spi_ena  = ena_q;
   assign spi_dc   = dc_q;
   assign spi_data = data_q;
endmodule

// File: doc/oled_spi_arb.md
Name: oled_spi_arb

Overview:
- Arbiter and sequencer that shares the single OLED SPI byte-writer between three requesters.
  - ch0: power-up init sequencer.
  - ch1: frame-buffer refresh reader.
  - ch2: user command port (contrast, display on/off).
- Owns the writer's ena/dc/data inputs and routes the writer's done pulse back to the granted channel.
- A lock input lets a channel keep the grant across a multi-byte sequence, so page-address commands and their 128 data bytes are never interleaved with another channel.

Parameters:
- NCH, 3, number of requesters; fixed at 3 in this revision.
- TIMEOUT_CYC, 4096, cycles allowed between spi_ena and spi_done; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-channel level request; the channel holds it high with dc/data stable until its done pulse
- lock  in  3  per-channel; high at transfer completion keeps the grant
- ch_dc  in  3  per-channel dc (0 = command, 1 = data)
- ch_data  in  24  per-channel byte, ch n at [8n+7:8n]
- gnt  out  3  one-hot current grant, or zero
- done  out  3  one-cycle completion pulse to the granted channel
- busy  out  1  high whenever state is not IDLE
- spi_ena  out  1  one-cycle start strobe to the SPI writer
- spi_dc  out  1  dc to the writer
- spi_data  out  8  byte to the writer
- spi_done  in  1  writer completion pulse
- timeout_err  out  1  one-cycle error pulse; present only with OLED_ARB_TIMEOUT_EN

Behaviour:
- Outputs: all registered. Reset value of every output is 0 (gnt, done, busy, spi_ena, spi_dc, spi_data, timeout_err). Reset asserted mid-transfer aborts immediately to IDLE. The SPI writer is not reset by this block.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If any req bit is high, grant by fixed priority ch0 > ch1 > ch2.
  - On the same edge: set gnt, capture that channel's ch_dc/ch_data into spi_dc/spi_data, go to ISSUE.
  - lock is ignored when there is no grant.
- ISSUE:
  - spi_ena = 1 for exactly this one cycle; next state WAIT.
  - Latency: req sampled high at edge k puts spi_ena high in the cycle after edge k.
- WAIT:
  - On spi_done, done[g] = 1 for exactly one cycle, starting the cycle after spi_done is sampled.
  - If lock[g] = 1 at that edge, go to HOLD with gnt kept. Otherwise go to IDLE and clear gnt.
  - spi_done outside WAIT is ignored.
  - Deasserting req[g] during WAIT does not abort the transfer; done is still pulsed.
- HOLD:
  - If req[g] = 1: capture its dc/data and go to ISSUE; no re-arbitration.
  - Else if lock[g] = 0: go to IDLE and clear gnt.
  - Else stay in HOLD. Other channels wait indefinitely; this starvation is intended.
- spi_dc/spi_data hold their last captured value between transfers.
- Back-to-back transfers: minimum 3 cycles from spi_done to the next spi_ena (done/IDLE or HOLD, then ISSUE).
- A requester must drop req, or present its next byte, in the cycle its done pulse is seen. A req still high one cycle after done is treated as a new request.

Optional Feature:
- OLED_ARB_TIMEOUT_EN defined:
  - A 13-bit counter clears on ISSUE and increments in WAIT.
  - If it reaches TIMEOUT_CYC with no spi_done: pulse done[g] and timeout_err for one cycle, force IDLE, clear gnt, ignore lock.
  - A late spi_done arriving afterwards is ignored.
- Not defined: WAIT lasts until spi_done, the counter is absent and the timeout_err port is absent.

Decomposition:
- Shared package oled_pkg:
  - State encoding constants ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_HOLD.
  - Channel indices CH_INIT = 0, CH_REFRESH = 1, CH_USER = 2, and NCH = 3.
- One natural sub-module: oled_arb_pick, a combinational fixed-priority one-hot picker (req in, one-hot out). Everything else stays in oled_spi_arb.

Test Plan:
- Single request: ch1 req with data 0xA5, dc = 1, writer answers spi_done 10 cycles after spi_ena -> gnt = 010, one spi_ena pulse, spi_data = 0xA5, spi_dc = 1, done = 010 for one cycle, busy drops 1 cycle later.
- Simultaneous req = 111 from IDLE -> service order ch0, ch1, ch2; exactly 3 spi_ena pulses and 3 done pulses in that order.
- Lock burst: ch1 lock = 1 sends cmd 0xB7, 0x00, 0x10 then 128 data bytes while ch2 req is held high -> ch2 receives no grant until ch1 drops lock; no ch2 byte is interleaved.
- Stray spi_done in IDLE and HOLD -> no done pulse, no state change.
- Reset asserted in WAIT -> all outputs 0 within the reset; after release with ch0 req high -> fresh spi_ena 1 cycle later.
- With OLED_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16 and no spi_done -> timeout_err and done[g] pulse 16 cycles after ISSUE; a late spi_done is ignored.
